// File: rtl/dmem_bus_if.sv
// Data-memory bus between the bridge (master) and the memory (slave).
// Valid/ready request channel plus a separate rvalid/rdata read-return channel.
interface dmem_bus_if #(
  parameter int ADDR_W = 32
);
  logic              bus_valid;
  logic              bus_ready;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [31:0]       bus_wdata;
  logic [3:0]        bus_strb;
  logic              bus_rvalid;
  logic [31:0]       bus_rdata;

  modport master (
    output bus_valid, bus_we, bus_addr, bus_wdata, bus_strb,
    input  bus_ready, bus_rvalid, bus_rdata
  );

  modport slave (
    input  bus_valid, bus_we, bus_addr, bus_wdata, bus_strb,
    output bus_ready, bus_rvalid, bus_rdata
  );
endinterface

// File: rtl/dmem_bus_bridge.sv
// Load/store-unit to data-memory bridge.
// Turns a single-cycle core data access into one valid/ready bus transaction
// and stalls the core until the transaction has completed. The raw 32-bit
// read word is returned; byte/half extraction stays in the LSU.
// Optional watchdog: define DMEM_TIMEOUT_EN to abort transactions that spend
// TIMEOUT_CYCLES cycles in REQ/RESP (rdata <= 32'hDEAD_BEEF, err pulses).
module dmem_bus_bridge #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_cs_n,
  input  logic              req_we,
  input  logic              req_re,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_mask,
  output logic              stall,
  output logic [31:0]       rdata,
  output logic              err,
  dmem_bus_if.master        bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg;
  logic [31:0]       wdata_reg;
  logic [3:0]        strb_reg;
  logic              we_reg;
  logic [31:0]       rdata_reg;

  logic              pending;
  logic              latch_req;
  logic              capture;
  logic              timeout_hit;
  logic              timeout_fire;
  logic              valid_int;

  // The byte offset only matters to the LSU's lane alignment, not to the bus.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^req_addr[1:0];

  // A write wins when both we and re are asserted.
  assign pending = !req_cs_n && (req_we || req_re);

`ifdef DMEM_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CNT_W-1:0] wdog_reg;
  logic             err_reg;

  // Fires on the TIMEOUT_CYCLES-th cycle spent in REQ/RESP; >= so a read that
  // handshakes on the last REQ cycle still times out on its first RESP cycle.
  assign timeout_hit = ((state_reg == REQ) || (state_reg == RESP)) &&
                       (wdog_reg >= CNT_W'(TIMEOUT_CYCLES - 1));

  // Watchdog counts REQ/RESP cycles and is zero on entry to REQ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_reg <= '0;
    end else if ((state_reg == REQ) || (state_reg == RESP)) begin
      wdog_reg <= wdog_reg + 1'b1;
    end else begin
      wdog_reg <= '0;
    end
  end

  // err is high exactly for the DONE cycle that follows a timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_reg <= 1'b0;
    end else begin
      err_reg <= timeout_fire;
    end
  end

  assign err = err_reg;
`else
  // The watchdog limit has no effect in this build.
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state, stall and handshake control.
  always_comb begin
    state_next   = state_reg;
    stall        = 1'b0;
    valid_int    = 1'b0;
    latch_req    = 1'b0;
    capture      = 1'b0;
    timeout_fire = 1'b0;
    case (state_reg)
      IDLE: begin
        if (pending) begin
          stall      = 1'b1;
          latch_req  = 1'b1;
          state_next = REQ;
        end
      end
      REQ: begin
        valid_int = 1'b1;
        stall     = 1'b1;
        if (bus.bus_ready) begin
          if (we_reg) begin
            state_next = DONE;
          end else if (bus.bus_rvalid) begin
            capture    = 1'b1;
            state_next = DONE;
          end else begin
            state_next = RESP;
          end
        end else if (timeout_hit) begin
          timeout_fire = 1'b1;
          state_next   = DONE;
        end
      end
      RESP: begin
        stall = 1'b1;
        if (bus.bus_rvalid) begin
          capture    = 1'b1;
          state_next = DONE;
        end else if (timeout_hit) begin
          timeout_fire = 1'b1;
          state_next   = DONE;
        end
      end
      DONE: begin
        // Core commits on this edge; the still-presented request is ignored.
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Request capture; fields stay stable until the next request is latched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_reg  <= '0;
      wdata_reg <= '0;
      strb_reg  <= '0;
      we_reg    <= 1'b0;
    end else if (latch_req) begin
      addr_reg  <= {req_addr[ADDR_W-1:2], 2'b00};
      wdata_reg <= req_wdata;
      strb_reg  <= req_we ? req_mask : 4'b1111;
      we_reg    <= req_we;
    end
  end

  // Read word register: only a read return or a timeout changes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_reg <= '0;
    end else if (capture) begin
      rdata_reg <= bus.bus_rdata;
    end else if (timeout_fire) begin
      rdata_reg <= 32'hDEAD_BEEF;
    end
  end

  assign rdata         = rdata_reg;
  assign bus.bus_valid = valid_int;
  assign bus.bus_we    = we_reg;
  assign bus.bus_addr  = addr_reg;
  assign bus.bus_wdata = wdata_reg;
  assign bus.bus_strb  = strb_reg;

endmodule
